// File: rtl/pixel_packer.sv
// Packs 4/8/10-bit debayer pixels MSB-first into 32-bit words and writes them to
// sequential frame-buffer addresses; reports per-frame word count, overflow and frame done.
module pixel_packer #(
    parameter int ADDRESS_WIDTH = 14
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic [3:0]               pixel_width_in,
    input  logic [9:0]               rgb10_in,
    input  logic [7:0]               rgb8_in,
    input  logic [3:0]               gray4_in,
    input  logic                     write_enable_in,
    input  logic                     frame_valid_in,
    output logic                     write_enable_out,
    output logic [31:0]              pixel_data_out,
    output logic [ADDRESS_WIDTH-1:0] address_out,
    output logic [ADDRESS_WIDTH:0]   word_count_out,
    output logic                     overflow_out,
    output logic                     frame_done_out
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
    typedef enum logic [1:0] {FMT_G4, FMT_R8, FMT_R10} fmt_t;

    typedef struct packed {
        logic                     we;
        logic [31:0]              data;
        logic [ADDRESS_WIDTH-1:0] addr;
    } wr_t;

    localparam logic [ADDRESS_WIDTH:0] FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    state_t                 state_q, state_d;
    fmt_t                   fmt_q, fmt_d, fmt_sel;
    logic                   fv_prev_q;
    logic [2:0]             cnt_q, cnt_d, cnt_eff, last_idx;
    logic [31:0]            acc_q, acc_d, field, emit_word;
    wr_t                    wr_q, wr_d;
    logic [ADDRESS_WIDTH:0] word_cnt_q, word_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic                   start, stop, accept, emit;

    function automatic fmt_t decode_fmt(input logic [3:0] w);
        case (w)
            4'd4:    decode_fmt = FMT_G4;
            4'd10:   decode_fmt = FMT_R10;
            default: decode_fmt = FMT_R8;
        endcase
    endfunction

    assign start = frame_valid_in & ~fv_prev_q;
    assign stop  = ~frame_valid_in & fv_prev_q;

    // The start-cycle pixel must use the freshly sampled width, not the stale latch.
    always_comb begin
        fmt_sel = fmt_q;
        cnt_eff = cnt_q;
        if (state_q == IDLE) begin
            fmt_sel = decode_fmt(pixel_width_in);
            cnt_eff = 3'd0;
        end
    end

    assign accept = write_enable_in & frame_valid_in &
                    (((state_q == IDLE) & start) | (state_q == CAPTURE));

    always_comb begin
        field    = '0;
        last_idx = 3'd3;
        case (fmt_sel)
            FMT_G4: begin
                field    = {gray4_in, 28'd0} >> {cnt_eff, 2'b00};
                last_idx = 3'd7;
            end
            FMT_R10: begin
                field    = {rgb10_in, 22'd0} >> (6'(cnt_eff) * 6'd10);
                last_idx = 3'd2;
            end
            default: begin
                field    = {rgb8_in, 24'd0} >> {cnt_eff, 3'b000};
                last_idx = 3'd3;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        fmt_d      = fmt_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        word_cnt_d = word_cnt_q;
        ovf_d      = ovf_q;
        wr_d       = wr_q;
        wr_d.we    = 1'b0;
        emit       = 1'b0;
        emit_word  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CAPTURE;
                    fmt_d      = fmt_sel;
                    word_cnt_d = '0;
                    ovf_d      = 1'b0;
                    // Every format needs at least 3 pixels, so pixel 0 never completes a word.
                    cnt_d      = accept ? 3'd1 : 3'd0;
                    acc_d      = accept ? field : 32'd0;
                end
            end
            CAPTURE: begin
                if (stop) begin
                    state_d = DONE;
                    if (cnt_q != 3'd0) begin
                        emit      = 1'b1;
                        emit_word = acc_q;
                    end
                    cnt_d = '0;
                    acc_d = '0;
                end else if (accept) begin
                    if (cnt_q == last_idx) begin
                        emit      = 1'b1;
                        emit_word = acc_q | field;
                        cnt_d     = '0;
                        acc_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        acc_d = acc_q | field;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // word_cnt_q saturates at FULL, so inequality means there is still room.
        if (emit) begin
            if (word_cnt_q != FULL) begin
                wr_d       = '{we: 1'b1, data: emit_word, addr: word_cnt_q[ADDRESS_WIDTH-1:0]};
                word_cnt_d = word_cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign done_d = (state_d == DONE);

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            fmt_q      <= FMT_R8;
            fv_prev_q  <= 1'b1;
            cnt_q      <= '0;
            acc_q      <= '0;
            wr_q       <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fmt_q      <= fmt_d;
            fv_prev_q  <= frame_valid_in;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            wr_q       <= wr_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign write_enable_out = wr_q.we;
    assign pixel_data_out   = wr_q.data;
    assign address_out      = wr_q.addr;
    assign word_count_out   = word_cnt_q;
    assign overflow_out     = ovf_q;
    assign frame_done_out   = done_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer: a full-size instance and a 4-word instance
// for the overflow case; expected writes are queued by stimulus and popped by a monitor.
module tb_pixel_packer;
    typedef struct {
        logic [31:0] data;
        logic [13:0] addr;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        use_b = 1'b0;
    logic        fv = 1'b0, we = 1'b0;
    logic [3:0]  pw = 4'd8, r4 = '0;
    logic [7:0]  r8 = '0;
    logic [9:0]  r10 = '0;
    logic        fv_a, we_a_in, fv_b, we_b_in;

    logic        we_a, ovf_a, fd_a;
    logic [31:0] data_a;
    logic [13:0] addr_a;
    logic [14:0] wc_a;
    logic        we_b, ovf_b, fd_b;
    logic [31:0] data_b;
    logic [1:0]  addr_b;
    logic [2:0]  wc_b;

    int checks = 0, errors = 0;
    int done_a = 0, done_b = 0;
    exp_t q_a[$], q_b[$];
    logic [9:0] pix[$];

    always #5 clk = ~clk;

    assign fv_a    = use_b ? 1'b0 : fv;
    assign we_a_in = use_b ? 1'b0 : we;
    assign fv_b    = use_b ? fv : 1'b0;
    assign we_b_in = use_b ? we : 1'b0;

    pixel_packer #(.ADDRESS_WIDTH(14)) dut_a (
        .clock_in(clk), .reset_in(rst), .pixel_width_in(pw), .rgb10_in(r10),
        .rgb8_in(r8), .gray4_in(r4), .write_enable_in(we_a_in), .frame_valid_in(fv_a),
        .write_enable_out(we_a), .pixel_data_out(data_a), .address_out(addr_a),
        .word_count_out(wc_a), .overflow_out(ovf_a), .frame_done_out(fd_a));

    pixel_packer #(.ADDRESS_WIDTH(2)) dut_b (
        .clock_in(clk), .reset_in(rst), .pixel_width_in(pw), .rgb10_in(r10),
        .rgb8_in(r8), .gray4_in(r4), .write_enable_in(we_b_in), .frame_valid_in(fv_b),
        .write_enable_out(we_b), .pixel_data_out(data_b), .address_out(addr_b),
        .word_count_out(wc_b), .overflow_out(ovf_b), .frame_done_out(fd_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] d, input logic [13:0] a, input logic dn);
        exp_t e;
        e.data = d; e.addr = a; e.done = dn;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] d, input logic [13:0] a, input logic dn);
        exp_t e;
        e.data = d; e.addr = a; e.done = dn;
        q_b.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (fd_a) done_a++;
            if (fd_b) done_b++;
            if (we_a) begin
                if (q_a.size() == 0) chk("unexpected write a", {32'd0, data_a}, 64'd0);
                else begin
                    e = q_a.pop_front();
                    chk("data a", {32'd0, data_a}, {32'd0, e.data});
                    chk("addr a", {50'd0, addr_a}, {50'd0, e.addr});
                    chk("done with write a", {63'd0, fd_a}, {63'd0, e.done});
                end
            end
            if (we_b) begin
                if (q_b.size() == 0) chk("unexpected write b", {32'd0, data_b}, 64'd0);
                else begin
                    e = q_b.pop_front();
                    chk("data b", {32'd0, data_b}, {32'd0, e.data});
                    chk("addr b", {62'd0, addr_b}, {50'd0, e.addr});
                    chk("done with write b", {63'd0, fd_b}, {63'd0, e.done});
                end
            end
        end
    endtask

    task automatic set_pix(input logic [9:0] p);
        r10 = p;
        r8  = p[7:0];
        r4  = p[3:0];
    endtask

    // Streams pix[] one per cycle starting in the start cycle, then ends the frame.
    task automatic run_frame(input logic [3:0] w, input bit chg_w);
        @(negedge clk);
        fv = 1'b1;
        pw = w;
        for (int i = 0; i < pix.size(); i++) begin
            we = 1'b1;
            set_pix(pix[i]);
            if (chg_w && i == 1) pw = 4'd4;
            @(negedge clk);
        end
        we = 1'b0;
        fv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(q_a.size() + q_b.size()), 64'd0);
    endtask

    initial begin
        int d0;
        fork
            monitor();
        join_none

        #2;
        chk("reset we_out", {63'd0, we_a}, 64'd0);
        chk("reset data", {32'd0, data_a}, 64'd0);
        chk("reset addr", {50'd0, addr_a}, 64'd0);
        chk("reset wc", {49'd0, wc_a}, 64'd0);
        chk("reset ovf/done", {62'd0, ovf_a, fd_a}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // rgb8, 8 pixels; width change mid-frame must be ignored
        d0 = done_a;
        pix.delete();
        for (int v = 1; v <= 8; v++) pix.push_back(10'(v));
        push_a(32'h01020304, 14'd0, 1'b0);
        push_a(32'h05060708, 14'd1, 1'b0);
        run_frame(4'd8, 1'b1);
        drain("rgb8 drain");
        chk("rgb8 wc", {49'd0, wc_a}, 64'd2);
        chk("rgb8 done pulses", 64'(done_a - d0), 64'd1);

        // gray4, 10 pixels -> flush in DONE
        d0 = done_a;
        pix.delete();
        for (int v = 1; v <= 10; v++) pix.push_back(10'(v));
        push_a(32'h12345678, 14'd0, 1'b0);
        push_a(32'h9A000000, 14'd1, 1'b1);
        run_frame(4'd4, 1'b0);
        drain("gray4 drain");
        chk("gray4 wc", {49'd0, wc_a}, 64'd2);
        chk("gray4 done pulses", 64'(done_a - d0), 64'd1);

        // rgb10, 4 pixels
        pix.delete();
        pix.push_back(10'h3FF); pix.push_back(10'h000);
        pix.push_back(10'h155); pix.push_back(10'h200);
        push_a(32'hFFC00554, 14'd0, 1'b0);
        push_a(32'h80000000, 14'd1, 1'b1);
        run_frame(4'd10, 1'b0);
        drain("rgb10 drain");
        chk("rgb10 wc", {49'd0, wc_a}, 64'd2);

        // overflow on the 4-word instance
        use_b = 1'b1;
        d0 = done_b;
        pix.delete();
        for (int v = 1; v <= 20; v++) pix.push_back(10'(v));
        push_b(32'h01020304, 14'd0, 1'b0);
        push_b(32'h05060708, 14'd1, 1'b0);
        push_b(32'h090A0B0C, 14'd2, 1'b0);
        push_b(32'h0D0E0F10, 14'd3, 1'b0);
        run_frame(4'd8, 1'b0);
        drain("ovf drain");
        chk("ovf flag", {63'd0, ovf_b}, 64'd1);
        chk("ovf wc", {61'd0, wc_b}, 64'd4);
        chk("ovf done pulses", 64'(done_b - d0), 64'd1);
        @(negedge clk);
        fv = 1'b1; we = 1'b1; pw = 4'd8; set_pix(10'hAA);
        push_b(32'hAA000000, 14'd0, 1'b1);
        @(posedge clk);
        #1;
        chk("start clears ovf", {63'd0, ovf_b}, 64'd0);
        chk("start clears wc", {61'd0, wc_b}, 64'd0);
        @(negedge clk);
        we = 1'b0; fv = 1'b0;
        repeat (3) @(negedge clk);
        drain("ovf next drain");
        chk("ovf next wc", {61'd0, wc_b}, 64'd1);
        use_b = 1'b0;

        // reset released mid-frame: stream ignored until fv falls and rises
        d0 = done_a;
        @(negedge clk);
        rst = 1'b1; fv = 1'b1; we = 1'b1; pw = 4'd8;
        @(negedge clk);
        rst = 1'b0;
        for (int v = 0; v < 8; v++) begin
            set_pix(10'(8'h40 + v));
            @(negedge clk);
        end
        we = 1'b0; fv = 1'b0;
        repeat (3) @(negedge clk);
        chk("inflight no done", 64'(done_a - d0), 64'd0);
        chk("inflight wc", {49'd0, wc_a}, 64'd0);
        pix.delete();
        for (int v = 0; v < 4; v++) pix.push_back(10'(8'h11 + v));
        push_a(32'h11121314, 14'd0, 1'b0);
        run_frame(4'd0, 1'b0);
        drain("width0 drain");
        chk("width0 wc", {49'd0, wc_a}, 64'd1);

        // reset mid-frame after 2 pixels
        d0 = done_a;
        @(negedge clk);
        fv = 1'b1; we = 1'b1; pw = 4'd8; set_pix(10'h21);
        @(negedge clk);
        set_pix(10'h22);
        @(negedge clk);
        we = 1'b0; rst = 1'b1;
        #1;
        chk("midrst outputs", {we_a, data_a, addr_a, wc_a, ovf_a, fd_a}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fv = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst no done", 64'(done_a - d0), 64'd0);
        pix.delete();
        for (int v = 0; v < 4; v++) pix.push_back(10'(8'h31 + v));
        push_a(32'h31323334, 14'd0, 1'b0);
        run_frame(4'd8, 1'b0);
        drain("after rst drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_packer.md
# pixel_packer

Packs the debayer's per-pixel output stream into 32-bit words and generates sequential write addresses for the camera frame buffer. It sits between the debayer stage and the buffer write port in the SPI clock domain. Frame boundaries come from the debayer frame-valid signal. It also reports a per-frame word count and a sticky overflow flag for the capture control logic.

## Interface
- ADDRESS_WIDTH, 14, width of buffer word address; buffer depth is 2^ADDRESS_WIDTH words
- clock_in  in  1  SPI-domain clock (72 MHz)
- reset_in  in  1  asynchronous, active-high reset
- pixel_width_in  in  4  pixel format: 4 = gray4, 8 = rgb8, 10 = rgb10; any other value is treated as 8; sampled only at frame start
- rgb10_in  in  10  10-bit pixel
- rgb8_in  in  8  8-bit pixel
- gray4_in  in  4  4-bit pixel
- write_enable_in  in  1  pixel valid strobe, one pixel per high cycle
- frame_valid_in  in  1  high for the duration of a frame
- write_enable_out  out  1  one-cycle buffer write strobe
- pixel_data_out  out  32  packed word, valid while write_enable_out is high
- address_out  out  ADDRESS_WIDTH  word address for the current write
- word_count_out  out  ADDRESS_WIDTH+1  words written this frame; saturates at 2^ADDRESS_WIDTH
- overflow_out  out  1  sticky: a word was dropped because the buffer was full
- frame_done_out  out  1  one-cycle pulse at the end of a frame

## Operation
- Edge detect: fv_prev is a register holding the previous frame_valid_in. It resets to 1, so a frame already in progress when reset releases is ignored.
  - Start cycle: frame_valid_in=1 and fv_prev=0.
  - End cycle: frame_valid_in=0 and fv_prev=1.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE -> CAPTURE on the start cycle. In that cycle: clear the pack counter, word_count_out, address and overflow_out; latch pixel_width_in. A pixel strobed in the start cycle is accepted as pixel 0.
  - CAPTURE -> DONE on the end cycle. If the pack counter is nonzero, the partial word is emitted with its unused low bits set to 0.
  - DONE -> IDLE unconditionally after 1 cycle. frame_done_out is high during DONE.
- Pixels arriving in IDLE or DONE, or with frame_valid_in=0, are ignored.
- Packing is MSB-first. The first pixel goes in the top field.
  - 8-bit: 4 pixels per word, in [31:24], [23:16], [15:8], [7:0].
  - 4-bit: 8 pixels per word, in [31:28] down to [3:0].
  - 10-bit: 3 pixels per word, in [31:22], [21:12], [11:2]; [1:0] = 0.
- The pack counter runs 0..N-1, where N is the number of pixels per word. Reaching N-1 with a pixel accepted completes the word and wraps the counter to 0.
- Completed or flushed word:
  - If word_count_out < 2^ADDRESS_WIDTH: write at address = word_count_out[ADDRESS_WIDTH-1:0], then increment word_count_out.
  - Otherwise: suppress the write and set overflow_out.
  - overflow_out stays set until the next start cycle.
- The pack accumulator clears after each emitted word, so padding is always 0.

## Timing
- Reset values: write_enable_out 0, pixel_data_out 0, address_out 0, word_count_out 0, overflow_out 0, frame_done_out 0, FSM in IDLE.
- Reset asserted mid-frame aborts the frame immediately. No flush and no frame_done_out pulse.
- Latency: write_enable_out is high exactly 1 cycle after the clock edge that accepts the completing pixel. pixel_data_out and address_out are registered and valid in that same cycle.
- Flush write, when present, is in the DONE cycle, coincident with frame_done_out.
- word_count_out updates in the same cycle as write_enable_out. It reflects the completed write count from the following cycle onward.
- Back-to-back pixels every cycle are supported. Consecutive writes can occur on consecutive cycles with no stalls. There is no backpressure.
- pixel_width_in changes during CAPTURE have no effect until the next frame.
- A start cycle occurring in DONE is missed; the upstream guarantees at least 2 low cycles between frames.

## Test plan
- rgb8 frame, 8 pixels 0x01..0x08, one per cycle -> two writes: 0x01020304 @ address 0, then 0x05060708 @ address 1; word_count_out=2; frame_done_out pulses once with no flush write.
- gray4 frame, 10 pixels 0x1..0xA -> 0x12345678 @ 0; flush 0x9A000000 @ 1 in the DONE cycle together with frame_done_out.
- rgb10 frame, pixels 0x3FF, 0x000, 0x155 -> 0xFFC00554 @ 0; a fourth pixel 0x200 -> flush 0x80000000 @ 1.
- ADDRESS_WIDTH=2, rgb8, 20 pixels -> writes at addresses 0..3 only; overflow_out=1; word_count_out=4. Next frame start clears both.
- Reset released while frame_valid_in=1 with pixels streaming -> no writes until frame_valid_in falls and rises again.
- Reset pulsed mid-frame after 2 of 4 pixels -> all outputs 0 immediately, no flush, no frame_done_out. Next frame starts at address 0.
